// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register with command handshake
//
// Purpose:
//   WIDTH-bit register that runs one command at a time: parallel load, clear,
//   or a multi-step shift (SHL, SHR, ROL, ROR, ASR), moving one bit position
//   per clock. It holds its value whenever no command is active.
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous, active-high reset
//   cmd_valid  in   1      command present
//   cmd_ready  out  1      command can be accepted this cycle
//   cmd_op     in   3      000 NOP, 001 LOAD, 010 SHL, 011 SHR, 100 ROL,
//                          101 ROR, 110 ASR, 111 CLR
//   cmd_amt    in   CNT_W  number of single-bit steps (shift ops only)
//   pin        in   WIDTH  parallel load data
//   sin_r      in   1      fill bit entering bit 0 on SHL
//   sin_l      in   1      fill bit entering bit WIDTH-1 on SHR
//   pout       out  WIDTH  register contents
//   sout_msb   out  1      pout[WIDTH-1]
//   sout_lsb   out  1      pout[0]
//   busy       out  1      a command is in progress (state != IDLE)
//   done       out  1      one-cycle pulse when a command completes
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_amt,
  input  logic [WIDTH-1:0] pin,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] pout,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_SHR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_ASR  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] data_q, data_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       op_q, op_n;
  logic             accept;
  logic             is_shift;

  // One single-bit step of a shift op. The serial fill bits are taken live,
  // so a multi-step SHL/SHR sees whatever sin_r/sin_l is on each edge.
  function automatic logic [WIDTH-1:0] step(input logic [2:0] op,
                                            input logic [WIDTH-1:0] p,
                                            input logic fill_l,
                                            input logic fill_r);
    logic [WIDTH-1:0] r;
    r = p;
    case (op)
      OP_SHL:  r = {p[WIDTH-2:0], fill_r};
      OP_SHR:  r = {fill_l, p[WIDTH-1:1]};
      OP_ROL:  r = {p[WIDTH-2:0], p[WIDTH-1]};
      OP_ROR:  r = {p[0], p[WIDTH-1:1]};
      OP_ASR:  r = {p[WIDTH-1], p[WIDTH-1:1]};
      default: r = p;
    endcase
    return r;
  endfunction

  assign cmd_ready = (state == IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign is_shift  = (cmd_op == OP_SHL) || (cmd_op == OP_SHR) || (cmd_op == OP_ROL) ||
                     (cmd_op == OP_ROR) || (cmd_op == OP_ASR);

  assign pout     = data_q;
  assign sout_msb = data_q[WIDTH-1];
  assign sout_lsb = data_q[0];
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  always_comb begin
    state_n = state;
    data_n  = data_q;
    cnt_n   = cnt;
    op_n    = op_q;
    case (state)
      IDLE: begin
        if (accept) begin
          op_n    = cmd_op;
          state_n = DONE;
          if (cmd_op == OP_LOAD) begin
            data_n = pin;
          end else if (cmd_op == OP_CLR) begin
            data_n = '0;
          end else if (is_shift && (cmd_amt != '0)) begin
            // The first step happens on the accept edge itself.
            data_n = step(cmd_op, data_q, sin_l, sin_r);
            if (cmd_amt != CNT_W'(1)) begin
              cnt_n   = cmd_amt - CNT_W'(1);
              state_n = SHIFT;
            end
          end
        end
      end
      SHIFT: begin
        data_n = step(op_q, data_q, sin_l, sin_r);
        cnt_n  = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      data_q <= '0;
      cnt    <= '0;
      op_q   <= OP_NOP;
    end else begin
      state  <= state_n;
      data_q <= data_n;
      cnt    <= cnt_n;
      op_q   <= op_n;
    end
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - directed self-checking bench for univ_shift_reg
module tb_univ_shift_reg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_SHR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_ASR  = 3'b110;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_amt;
  logic [7:0] pin;
  logic       sin_r;
  logic       sin_l;
  logic [7:0] pout;
  logic       sout_msb;
  logic       sout_lsb;
  logic       busy;
  logic       done;

  int checks;
  int failures;

  univ_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_amt  (cmd_amt),
    .pin      (pin),
    .sin_r    (sin_r),
    .sin_l    (sin_l),
    .pout     (pout),
    .sout_msb (sout_msb),
    .sout_lsb (sout_lsb),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command for exactly one accept edge, then withdraw it.
  task automatic issue(input logic [2:0] op, input logic [3:0] amt, input logic [7:0] data);
    cmd_op    = op;
    cmd_amt   = amt;
    pin       = data;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!cmd_ready && n < 40) begin
      tick();
      n++;
    end
    check(tag, {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    int edges;
    int dones;
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    cmd_amt   = 4'd0;
    pin       = 8'h00;
    sin_r     = 1'b0;
    sin_l     = 1'b0;

    // 1: reset
    tick();
    tick();
    check("rst_ready_low", {31'd0, cmd_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_pout", {24'd0, pout}, 32'h00);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);

    // 2: LOAD 0xA5
    issue(OP_LOAD, 4'd0, 8'hA5);
    check("load_pout", {24'd0, pout}, 32'hA5);
    check("load_done", {31'd0, done}, 32'd1);
    check("load_ready_low", {31'd0, cmd_ready}, 32'd0);
    check("load_sout", {30'd0, sout_msb, sout_lsb}, 32'd3);
    tick();
    check("load_done_clr", {31'd0, done}, 32'd0);
    check("load_ready", {31'd0, cmd_ready}, 32'd1);
    check("load_busy", {31'd0, busy}, 32'd0);

    // 3: SHL by 3 with sin_r=1
    sin_r = 1'b1;
    issue(OP_SHL, 4'd3, 8'h00);
    check("shl_s1", {24'd0, pout}, 32'h4B);
    check("shl_s1_done", {31'd0, done}, 32'd0);
    check("shl_s1_busy", {31'd0, busy}, 32'd1);
    tick();
    check("shl_s2", {24'd0, pout}, 32'h97);
    check("shl_s2_done", {31'd0, done}, 32'd0);
    tick();
    check("shl_s3", {24'd0, pout}, 32'h2F);
    check("shl_s3_done", {31'd0, done}, 32'd1);
    check("shl_sout", {30'd0, sout_msb, sout_lsb}, 32'd1);
    tick();
    check("shl_end_done", {31'd0, done}, 32'd0);
    check("shl_end_ready", {31'd0, cmd_ready}, 32'd1);
    check("shl_end_pout", {24'd0, pout}, 32'h2F);
    sin_r = 1'b0;

    // 4: ROR by 8 restores value; held cmd_valid ignored while busy
    issue(OP_LOAD, 4'd0, 8'h96);
    wait_ready("ror_pre_ready");
    issue(OP_ROR, 4'd8, 8'h00);
    cmd_valid = 1'b1;
    cmd_op    = OP_LOAD;
    pin       = 8'h00;
    edges     = 1;
    dones     = 0;
    while (!cmd_ready && edges < 40) begin
      if (done) dones++;
      tick();
      edges++;
    end
    cmd_valid = 1'b0;
    check("ror_edges", edges, 32'd9);
    check("ror_dones", dones, 32'd1);
    check("ror_pout", {24'd0, pout}, 32'h96);
    tick();
    check("ror_hold_pout", {24'd0, pout}, 32'h96);

    // 5: ASR by 2, then SHR by 0
    wait_ready("asr_pre_ready");
    issue(OP_LOAD, 4'd0, 8'h90);
    wait_ready("asr_load_ready");
    issue(OP_ASR, 4'd2, 8'h00);
    check("asr_s1", {24'd0, pout}, 32'hC8);
    tick();
    check("asr_s2", {24'd0, pout}, 32'hE4);
    check("asr_done", {31'd0, done}, 32'd1);
    wait_ready("asr_ready");
    issue(OP_SHR, 4'd0, 8'h00);
    check("shr0_pout", {24'd0, pout}, 32'hE4);
    check("shr0_done", {31'd0, done}, 32'd1);
    tick();
    check("shr0_ready", {31'd0, cmd_ready}, 32'd1);

    // 6: SHR by 5 aborted by reset after 2 steps
    issue(OP_LOAD, 4'd0, 8'hFF);
    wait_ready("abort_pre_ready");
    sin_l = 1'b0;
    issue(OP_SHR, 4'd5, 8'h00);
    check("abort_s1", {24'd0, pout}, 32'h7F);
    tick();
    check("abort_s2", {24'd0, pout}, 32'h3F);
    rst = 1'b1;
    tick();
    check("abort_pout", {24'd0, pout}, 32'h00);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ready_in_rst", {31'd0, cmd_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("abort_ready_after", {31'd0, cmd_ready}, 32'd1);
    issue(OP_LOAD, 4'd0, 8'h3C);
    check("post_rst_load", {24'd0, pout}, 32'h3C);
    check("post_rst_done", {31'd0, done}, 32'd1);

    // ROL by 1, and SHR with sin_l=1
    wait_ready("rol_pre_ready");
    issue(OP_ROL, 4'd1, 8'h00);
    check("rol_pout", {24'd0, pout}, 32'h78);
    check("rol_done", {31'd0, done}, 32'd1);
    wait_ready("shr1_pre_ready");
    sin_l = 1'b1;
    issue(OP_SHR, 4'd1, 8'h00);
    check("shr1_pout", {24'd0, pout}, 32'hBC);
    sin_l = 1'b0;
    wait_ready("final_ready");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
